data_sram_responder: RTL

Responder end of the CPU data SRAM port (`en`/`wen`/`addr`/`wdata`/`rdata`). Replaces the bare data RAM beside the CPU in the SoC top: it decodes each access to either a word-addressed, byte-writable RAM or a small memory-mapped register bank (LED, switch, free-running timer). Read data returns one clock after the request, matching the CPU's SRAM-style timing.

---
 rtl/dsram_pkg.sv | 21 ++
 rtl/dsram_conf_regs.sv | 95 +++++++++
 rtl/data_sram_responder.sv | 79 +++++++
 3 files changed

// File: rtl/dsram_pkg.sv
// Shared constants and helpers for the data SRAM responder.
// Register offsets are the low 16 address bits inside the register-bank window.
// byte_merge applies per-byte write enables to an existing 32-bit word.
package dsram_pkg;

    localparam logic [15:0] LED_OFF    = 16'hF000;
    localparam logic [15:0] SWITCH_OFF = 16'hF004;
    localparam logic [15:0] TIMER_OFF  = 16'hE000;

    // Byte i of the result comes from new_w when wen[i] is set, else from old_w.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  wen);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = wen[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dsram_conf_regs.sv
// Memory-mapped register bank: LED (R/W, 16 bit), SWITCH (RO), TIMER (R/W, free-running).
// Ports: sel/wen/off/wdata describe the access this cycle; rd_dat is the combinational
// pre-write read value; led_out is the LED register. TIMER exists only with DSRAM_TIMER_EN.
module dsram_conf_regs
    import dsram_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [3:0]  wen,
    input  logic [15:0] off,
    input  logic [31:0] wdata,
    input  logic [15:0] switch_in,
    output logic [31:0] rd_dat,
    output logic [15:0] led_out
);

    logic [15:0] led_q, led_d;
    logic [31:0] led_merge;
    logic        hit_led;
    logic        hit_sw;

    assign hit_led   = (off == LED_OFF);
    assign hit_sw    = (off == SWITCH_OFF);
    // LED only has bytes 0-1; upper enables are masked off.
    assign led_merge = byte_merge({16'h0, led_q}, wdata, {2'b00, wen[1:0]});

    always_comb begin
        led_d = led_q;
        if (sel && hit_led) begin
            led_d = led_merge[15:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q <= 16'h0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_out = led_q;

`ifdef DSRAM_TIMER_EN
    logic [31:0] timer_q, timer_d;
    logic        hit_tmr;

    assign hit_tmr = (off == TIMER_OFF);

    // A write (any enable set) replaces the count for this cycle instead of incrementing.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (sel && hit_tmr && (wen != 4'b0000)) begin
            timer_d = byte_merge(timer_q, wdata, wen);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= 32'h0;
        end else begin
            timer_q <= timer_d;
        end
    end

    always_comb begin
        rd_dat = 32'h0;
        if (hit_led) begin
            rd_dat = {16'h0, led_q};
        end else if (hit_sw) begin
            rd_dat = {16'h0, switch_in};
        end else if (hit_tmr) begin
            rd_dat = timer_q;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{led_merge[31:16]};
`else
    always_comb begin
        rd_dat = 32'h0;
        if (hit_led) begin
            rd_dat = {16'h0, led_q};
        end else if (hit_sw) begin
            rd_dat = {16'h0, switch_in};
        end
    end

    // Without the timer nothing consumes the upper write bytes.
    logic unused_ok;
    assign unused_ok = ^{led_merge[31:16], wen[3:2], wdata[31:16]};
`endif

endmodule

// File: rtl/data_sram_responder.sv
// Responder for the CPU data SRAM port: decodes to a byte-writable RAM or the register bank.
// Ports: en/wen/addr/wdata request, rdata registered 1 cycle later (read-first), holds when en=0;
// switch_in/led_out board I/O. Optional TIMER register enabled by DSRAM_TIMER_EN.
module data_sram_responder
    import dsram_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [15:0] CONF_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   ram [DEPTH];
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_rd;
    logic          is_conf;
    logic          conf_sel;
    logic          ram_we;
    logic [31:0]   conf_rd;
    logic [31:0]   rdata_q, rdata_d;

    // Upper address bits above the RAM index are dropped, so RAM accesses wrap.
    assign ram_idx  = addr[AW+1:2];
    assign ram_rd   = ram[ram_idx];
    assign is_conf  = (addr[31:16] == CONF_HI);
    assign conf_sel = en && is_conf;
    assign ram_we   = en && !is_conf && (wen != 4'b0000);

    dsram_conf_regs u_conf_regs (
        .clk       (clk),
        .resetn    (resetn),
        .sel       (conf_sel),
        .wen       (wen),
        .off       ({addr[15:2], 2'b00}),
        .wdata     (wdata),
        .switch_in (switch_in),
        .rd_dat    (conf_rd),
        .led_out   (led_out)
    );

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= byte_merge(ram_rd, wdata, wen);
        end
    end

    // Read-first: capture the value present before this cycle's write.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = is_conf ? conf_rd : ram_rd;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'h0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

    logic unused_ok;
    assign unused_ok = ^{addr[1:0]};

endmodule
